// File: rtl/dsm_sched_pkg.sv
// dsm_sched_pkg
//   Shared definitions for the delta-sigma OSR scheduler:
//   - sched_state_t    : scheduler FSM states
//   - UNDERRUN_CNT_W   : width of the saturating underrun counter
//   - MUTE_VALUE       : sample presented when muted (midscale, signed zero)
package dsm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } sched_state_t;

  localparam int UNDERRUN_CNT_W = 16;
  localparam int MUTE_VALUE     = 0;

endpackage

// File: rtl/dsm_tick_gen.sv
// dsm_tick_gen
//   Programmable tick divider. Fires one tick every div_q+1 unstalled cycles.
//   Ports:
//     aclk, arst_n : clock, asynchronous active-low reset
//     clear        : hold the divider at zero (no ticks while high)
//     stall        : freeze the divider and suppress ticks (beat pending)
//     div_q        : tick period minus one, in aclk cycles
//     tick         : single-cycle tick strobe (combinational from cnt_reg)
module dsm_tick_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 arst_n,
  input  logic                 clear,
  input  logic                 stall,
  input  logic [DIV_WIDTH-1:0] div_q,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_reg;

  assign tick = !clear && !stall && (cnt_reg == div_q);

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_reg <= '0;
    end else if (clear || tick) begin
      cnt_reg <= '0;
    end else if (!stall) begin
      cnt_reg <= cnt_reg + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dsm_osr_scheduler.sv
// dsm_osr_scheduler
//   Converts a bursty PCM AXI-Stream into an evenly spaced modulator strobe
//   stream, holding each sample for 2^OSR_LOG2 beats.
//   Ports:
//     aclk, arst_n        : clock, asynchronous active-low reset
//     cfg_enable          : run request (level)
//     cfg_div             : tick period minus one, latched on IDLE->PRIME
//     s_axis_pcm_*        : upstream PCM samples (tdata/tvalid/tready)
//     m_axis_dsm_*        : samples to the modulator (tdata/tvalid/tready)
//     status_running      : high in PRIME, RUN and STOP
//     status_underrun     : one-cycle pulse per underrun
//     underrun_count      : saturating underrun counter, cleared by reset only
module dsm_osr_scheduler
  import dsm_sched_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OSR_LOG2  = 6,
  parameter int DIV_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      arst_n,
  input  logic                      cfg_enable,
  input  logic [DIV_WIDTH-1:0]      cfg_div,
  input  logic signed [WIDTH-1:0]   s_axis_pcm_tdata,
  input  logic                      s_axis_pcm_tvalid,
  output logic                      s_axis_pcm_tready,
  output logic signed [WIDTH-1:0]   m_axis_dsm_tdata,
  output logic                      m_axis_dsm_tvalid,
  input  logic                      m_axis_dsm_tready,
  output logic                      status_running,
  output logic                      status_underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

  localparam logic signed [WIDTH-1:0]   MUTE     = WIDTH'(MUTE_VALUE);
  localparam logic [OSR_LOG2-1:0]       REP_LAST = '1;
  localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX  = '1;

  sched_state_t              state_reg;
  logic [DIV_WIDTH-1:0]      div_q_reg;
  logic signed [WIDTH-1:0]   cur_reg;
  logic signed [WIDTH-1:0]   nxt_reg;
  logic                      nxt_full_reg;
  logic [OSR_LOG2-1:0]       rep_reg;
  logic                      tvalid_reg;
  logic                      underrun_reg;
  logic [UNDERRUN_CNT_W-1:0] ucnt_reg;

  logic pcm_fire;
  logic beat;
  logic reload;
  logic tick;
  logic tick_clear;
  logic tick_stall;

  assign s_axis_pcm_tready = ((state_reg == PRIME) || (state_reg == RUN)) && !nxt_full_reg;
  assign pcm_fire          = s_axis_pcm_tvalid && s_axis_pcm_tready;
  assign beat              = tvalid_reg && m_axis_dsm_tready;
  assign reload            = beat && (rep_reg == REP_LAST);

  // Divider only runs while beats are being produced; it freezes while the
  // modulator holds off a pending beat so no tick is ever lost.
  assign tick_clear = (state_reg == IDLE) || (state_reg == PRIME);
  assign tick_stall = tvalid_reg && !m_axis_dsm_tready;

  dsm_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .aclk   (aclk),
    .arst_n (arst_n),
    .clear  (tick_clear),
    .stall  (tick_stall),
    .div_q  (div_q_reg),
    .tick   (tick)
  );

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= IDLE;
      div_q_reg    <= '0;
      cur_reg      <= MUTE;
      nxt_reg      <= MUTE;
      nxt_full_reg <= 1'b0;
      rep_reg      <= '0;
      tvalid_reg   <= 1'b0;
      underrun_reg <= 1'b0;
      ucnt_reg     <= '0;
    end else begin
      underrun_reg <= 1'b0;

      if (tick) begin
        tvalid_reg <= 1'b1;
      end else if (beat) begin
        tvalid_reg <= 1'b0;
      end

      if (beat) begin
        rep_reg <= rep_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          tvalid_reg   <= 1'b0;
          rep_reg      <= '0;
          cur_reg      <= MUTE;
          nxt_full_reg <= 1'b0;
          if (cfg_enable) begin
            div_q_reg <= cfg_div;
            state_reg <= PRIME;
          end
        end

        PRIME: begin
          if (nxt_full_reg) begin
            cur_reg      <= nxt_reg;
            nxt_full_reg <= 1'b0;
            state_reg    <= RUN;
          end else if (pcm_fire) begin
            nxt_reg      <= s_axis_pcm_tdata;
            nxt_full_reg <= 1'b1;
          end else if (!cfg_enable) begin
            state_reg <= IDLE;
          end
        end

        RUN: begin
          if (reload) begin
            if (!cfg_enable) begin
              // Stop request: mute instead of reloading. A sample caught in
              // this cycle lands in nxt and is discarded by the STOP flush.
              state_reg <= STOP;
              cur_reg   <= MUTE;
              if (pcm_fire) begin
                nxt_reg      <= s_axis_pcm_tdata;
                nxt_full_reg <= 1'b1;
              end
            end else if (nxt_full_reg) begin
              cur_reg      <= nxt_reg;
              nxt_full_reg <= 1'b0;
            end else if (pcm_fire) begin
              // Sample arrived exactly on the reload beat: bypass nxt.
              cur_reg <= s_axis_pcm_tdata;
            end else begin
              cur_reg      <= MUTE;
              underrun_reg <= 1'b1;
              if (ucnt_reg != CNT_MAX) begin
                ucnt_reg <= ucnt_reg + 1'b1;
              end
            end
          end else if (pcm_fire) begin
            nxt_reg      <= s_axis_pcm_tdata;
            nxt_full_reg <= 1'b1;
          end
        end

        STOP: begin
          // rep wrapped to zero on entry, so the next reload beat closes a
          // full OSR period of mute.
          if (reload) begin
            tvalid_reg   <= 1'b0;
            nxt_full_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis_dsm_tdata  = cur_reg;
  assign m_axis_dsm_tvalid = tvalid_reg;
  assign status_running    = (state_reg != IDLE);
  assign status_underrun   = underrun_reg;
  assign underrun_count    = ucnt_reg;

endmodule

// File: tb/tb_dsm_osr_scheduler.sv
// tb_dsm_osr_scheduler
//   Directed scoreboard bench for dsm_osr_scheduler with OSR_LOG2=2 and
//   cfg_div=3 (one beat every 4 cycles, 4 beats per sample).
//   Beat sequence expected by the scoreboard:
//     0-3 0x1234 | 4-7 0x4000 | 8-11 0x0100 | 12-23 mute (3 underruns)
//     24-27 0x5A5A (bypass, backpressure) | 28-31 0x7FFF | 32-35 mute (STOP)
//     36-37 0x2222 (after restart; reset follows)
module tb_dsm_osr_scheduler;

  localparam int WIDTH     = 16;
  localparam int OSR_LOG2  = 2;
  localparam int DIV_WIDTH = 8;
  localparam int TIMEOUT   = 2000;

  logic                 aclk       = 1'b0;
  logic                 arst_n     = 1'b1;
  logic                 cfg_enable = 1'b0;
  logic [DIV_WIDTH-1:0] cfg_div    = '0;
  logic [WIDTH-1:0]     s_tdata    = '0;
  logic                 s_tvalid   = 1'b0;
  logic                 s_tready;
  logic [WIDTH-1:0]     m_tdata;
  logic                 m_tvalid;
  logic                 m_tready   = 1'b1;
  logic                 status_running;
  logic                 status_underrun;
  logic [15:0]          underrun_count;

  int compared   = 0;
  int mismatched = 0;
  int beat_n     = 0;
  int pulses     = 0;
  int cyc        = 0;
  int last_cyc   = 0;
  bit mon_pend   = 1'b0;
  logic [WIDTH-1:0] pend_data = '0;
  logic [WIDTH-1:0] exp_q[$];

  dsm_osr_scheduler #(
    .WIDTH     (WIDTH),
    .OSR_LOG2  (OSR_LOG2),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .aclk              (aclk),
    .arst_n            (arst_n),
    .cfg_enable        (cfg_enable),
    .cfg_div           (cfg_div),
    .s_axis_pcm_tdata  (s_tdata),
    .s_axis_pcm_tvalid (s_tvalid),
    .s_axis_pcm_tready (s_tready),
    .m_axis_dsm_tdata  (m_tdata),
    .m_axis_dsm_tvalid (m_tvalid),
    .m_axis_dsm_tready (m_tready),
    .status_running    (status_running),
    .status_underrun   (status_underrun),
    .underrun_count    (underrun_count)
  );

  always #5 aclk = ~aclk;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic push_n(input logic [WIDTH-1:0] d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(d);
  endtask

  // Offer one sample upstream and hold it until the scheduler takes it.
  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_tready && n < TIMEOUT);
    if (!s_tready) timeout_fail("send");
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (beat_n < n && t < TIMEOUT) begin
      @(posedge aclk);
      t++;
    end
    if (beat_n < n) timeout_fail("wait_beats");
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks that a
  // stalled beat keeps tvalid and tdata stable.
  initial forever begin
    logic [WIDTH-1:0] exp_d;
    @(negedge aclk);
    if (!arst_n) begin
      mon_pend = 1'b0;
    end else begin
      if (mon_pend) begin
        check("hold_valid", 32'(m_tvalid), 32'd1);
        check("hold_data", 32'(m_tdata), 32'(pend_data));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got %h with no beat expected", m_tdata);
        end else begin
          exp_d = exp_q.pop_front();
          check("beat_data", 32'(m_tdata), 32'(exp_d));
        end
        if (beat_n >= 1 && beat_n <= 7) check("beat_interval", 32'(cyc - last_cyc), 32'd4);
        $display("beat %0d data %h underrun_count %0d", beat_n, m_tdata, underrun_count);
        last_cyc = cyc;
        beat_n++;
      end
      if (status_underrun) pulses++;
      mon_pend  = m_tvalid && !m_tready;
      pend_data = m_tdata;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 arst_n = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_running", 32'(status_running), 32'd0);
    check("rst_underrun", 32'(status_underrun), 32'd0);
    check("rst_count", 32'(underrun_count), 32'd0);

    arst_n = 1'b1;
    @(posedge aclk);
    #1;
    cfg_div    = 8'd3;
    cfg_enable = 1'b1;

    // Basic run, then one more sample followed by starvation.
    push_n(16'h1234, 4);
    send(16'h1234);
    push_n(16'h4000, 4);
    send(16'h4000);
    push_n(16'h0100, 4);
    send(16'h0100);
    push_n(16'h0000, 12);

    // Bypass: offer a sample exactly while reload beat 23 is presented.
    wait_beats(23);
    begin
      int t;
      t = 0;
      do begin
        @(negedge aclk);
        t++;
      end while (!m_tvalid && t < TIMEOUT);
      if (!m_tvalid) timeout_fail("bypass_wait");
    end
    check("bypass_tready", 32'(s_tready), 32'd1);
    push_n(16'h5A5A, 4);
    s_tdata  = 16'h5A5A;
    s_tvalid = 1'b1;
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
    check("bypass_no_pulse", 32'(status_underrun), 32'd0);
    check("bypass_count", 32'(underrun_count), 32'd3);

    push_n(16'h7FFF, 4);
    send(16'h7FFF);

    // Backpressure for 10 cycles in the middle of the 0x5A5A period.
    wait_beats(25);
    #1 m_tready = 1'b0;
    repeat (10) @(posedge aclk);
    #1 m_tready = 1'b1;

    // This sample sits in nxt and must be flushed by the stop sequence.
    send(16'h1111);

    // Stop mid-period: 0x7FFF finishes, then one period of mute.
    wait_beats(29);
    #1 cfg_enable = 1'b0;
    push_n(16'h0000, 4);
    wait_beats(33);
    @(negedge aclk);
    check("stop_tready", 32'(s_tready), 32'd0);
    check("stop_running", 32'(status_running), 32'd1);
    wait_beats(36);
    #1;
    check("idle_tvalid", 32'(m_tvalid), 32'd0);
    check("idle_running", 32'(status_running), 32'd0);
    check("underrun_pulses", 32'(pulses), 32'd3);
    check("underrun_count", 32'(underrun_count), 32'd3);

    // Restart: the first beats must be the new sample, not the flushed one.
    cfg_enable = 1'b1;
    push_n(16'h2222, 2);
    send(16'h2222);
    wait_beats(38);

    // Reset pulse mid-run: outputs clear without waiting for a clock edge.
    #2 arst_n = 1'b0;
    #1;
    check("arst_tvalid", 32'(m_tvalid), 32'd0);
    check("arst_tready", 32'(s_tready), 32'd0);
    check("arst_tdata", 32'(m_tdata), 32'd0);
    check("arst_running", 32'(status_running), 32'd0);
    check("arst_count", 32'(underrun_count), 32'd0);
    #6 arst_n = 1'b1;
    cfg_enable = 1'b0;
    repeat (6) @(posedge aclk);
    #1;
    check("post_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("post_rst_running", 32'(status_running), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
